alu_seq: RTL
============

# alu_seq

Sequential, parametrised successor to the datapath's combinational ALU. It keeps the existing 4-bit operation encoding and adds a valid/ready handshake, iterative multiply/divide with a high-word output, and overflow and error flags. It sits between operand fetch and writeback; the datapath stalls on `in_ready`/`out_valid`.

## Interface
Parameters
- `WIDTH`, 32: operand and result width, ≥ 4.

Ports
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands and `sel` valid this cycle.
- `in_ready`  out  1  block can accept a new operation.
- `a`, `b`  in  WIDTH  operands.
- `sel`  in  4  operation code.
- `out_valid`  out  1  result registers valid.
- `out_ready`  in  1  consumer takes the result.
- `res`  out  WIDTH  result: low product or quotient for MUL/DIV.
- `res_hi`  out  WIDTH  high product half for MUL, remainder for DIV, 0 for all other ops.
- `zf`  out  1  `res == 0`.
- `ovf`  out  1  signed overflow on ADD/SUB; `res_hi != 0` on MUL.
- `err`  out  1  illegal `sel`, or divide by zero.

## Operation
- Operation codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0100 NOR; 0110 SUB; 0111 XOR.
  - 0101 MUL, unsigned.
  - 1000 DIV, unsigned.
  - 1001 SLT, unsigned: `res` = 1 if `a < b`, else 0.
  - 1011 SGEZ: `res` = 1 if `a[WIDTH-1]` = 0, else 0.
  - 1101: `res` = 0.
  - 1110: `res` = all ones.
- All other codes: `res` = 0, `res_hi` = 0, `err` = 1.
- A transfer is accepted when `in_valid && in_ready`. Operands and `sel` are captured into internal registers; later changes on the inputs have no effect.
- State machine:
  - IDLE: `in_ready` = 1. Accepting MUL goes to MUL; accepting DIV with `b` ≠ 0 goes to DIV; accepting any other op goes to DONE with the result registered.
  - MUL: shift-add, one bit of `b` per cycle. Runs WIDTH cycles, then goes to DONE.
  - DIV: restoring division, one quotient bit per cycle. Runs WIDTH cycles, then goes to DONE.
  - DONE: `out_valid` = 1 and result registers held stable. Goes to IDLE on `out_ready`.
- Divide by zero: goes straight from IDLE to DONE with `res` = all ones, `res_hi` = `a`, `err` = 1.
- Widths: ADD/SUB wrap modulo 2^WIDTH. `ovf` for ADD/SUB is the signed overflow; `ovf` is 0 for all ops other than ADD, SUB and MUL.
- `zf` is derived from the registered `res` only, never from `res_hi`.

## Timing
- Reset: state IDLE; `in_ready` = 1; `out_valid` = 0; `res`, `res_hi`, `ovf`, `err` = 0; `zf` = 1.
- Latency is measured from the accept edge N:
  - single-cycle ops: `out_valid` high at N+1;
  - MUL and DIV: `out_valid` high at N+1+WIDTH;
  - divide by zero: `out_valid` high at N+1.
- `in_ready` is low in MUL, DIV and DONE; there is no overlap of operations.
- Throughput for single-cycle ops is at best one operation per 2 cycles.
- Backpressure: DONE with `out_ready` = 0 holds indefinitely with all outputs stable.
- Taking the result (`out_ready` in DONE) returns the block to IDLE on the next edge. `in_valid` presented in that same cycle is not accepted.
- `rst` asserted mid-MUL/DIV or in DONE: the operation is aborted and all outputs take their reset values on the next edge. No result is produced.

## Configuration
- `ALU_SEQ_MULDIV_EN` defined: MUL and DIV are implemented as described above.
- Undefined:
  - the MUL and DIV states and datapath are removed;
  - codes 0101 and 1000 are treated as illegal: `res` = 0, `err` = 1, result in DONE at N+1;
  - `res_hi` is tied to 0.

## Structure
- Shared package `alu_seq_pkg`:
  - opcode localparams (OP_AND … OP_ONES);
  - the state enum (ST_IDLE, ST_MUL, ST_DIV, ST_DONE).
- The combinational single-cycle ops stay in `alu_seq`.
- The iterative engine is one sub-module, `alu_seq_muldiv`: start/done handshake with `alu_seq`, shared WIDTH-cycle counter, compiled only under `ALU_SEQ_MULDIV_EN`.

## Test plan
- ADD `a`=0x7FFFFFFF, `b`=1 → at N+1 `res`=0x80000000, `ovf`=1, `zf`=0, `err`=0.
- SUB `a`=5, `b`=5 with `out_ready` held low 3 cycles → `res`=0 and `zf`=1 held stable; block returns to IDLE one cycle after `out_ready` rises.
- MUL 0xFFFFFFFF × 2 → `out_valid` at N+33, `res`=0xFFFFFFFE, `res_hi`=1, `ovf`=1.
- DIV 100 / 7 → `out_valid` at N+33, `res`=14, `res_hi`=2; DIV 9 / 0 → at N+1 `res`=0xFFFFFFFF, `res_hi`=9, `err`=1.
- `sel`=0011 → at N+1 `res`=0, `err`=1, `zf`=1; SGEZ `a`=0x80000000 → `res`=0.
- `rst` pulsed at cycle 10 of a MUL → next edge IDLE, `out_valid`=0, `in_ready`=1; no `out_valid` pulse follows.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the sequential ALU:
//   - 4-bit operation codes (unchanged from the combinational ALU)
//   - controller state encoding
//   - small helpers for signed-overflow detection
// Used by alu_seq and alu_seq_muldiv (the latter only when
// ALU_SEQ_MULDIV_EN is defined).
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_MUL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SGEZ = 4'b1011;
    localparam logic [3:0] OP_ZERO = 4'b1101;
    localparam logic [3:0] OP_ONES = 4'b1110;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_MUL  = 2'd1;
    localparam state_t ST_DIV  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Signed overflow of a + b: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    // Signed overflow of a - b: operands differ in sign, result sign differs from a.
    function automatic logic sub_ovf(input logic sa, input logic sb, input logic ss);
        return (sa != sb) && (ss != sa);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv
// Iterative unsigned multiply / restoring divide engine for alu_seq.
// Compiled only when ALU_SEQ_MULDIV_EN is defined.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         load operands and begin (one-cycle pulse from alu_seq)
//   is_div        1 = divide a / b, 0 = multiply a * b
//   a, b          operands, sampled on start
//   done          high during the final iteration cycle
//   lo, hi        value the {lo,hi} pair takes after the current iteration;
//                 when done is high this is the final result
//                 (MUL: low/high product, DIV: quotient/remainder)
//
// Both operations share one WIDTH-iteration counter and one hi/lo shift
// pair. MUL: lo starts as the multiplier and is shifted out LSB first while
// the product shifts in from the top. DIV: lo starts as the dividend,
// shifted out MSB first into the partial remainder (hi) while quotient bits
// shift in at the bottom.
`ifdef ALU_SEQ_MULDIV_EN
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic             busy_reg;
    logic             div_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] opnd_reg;   // multiplicand (MUL) or divisor (DIV)

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] hi_next;
    logic [WIDTH-1:0] lo_next;

    always_comb begin
        mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
        div_sh  = {hi_reg, lo_reg[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, opnd_reg});
        // When div_ge holds the true difference is below the divisor, so the
        // low WIDTH bits of the modular subtraction are exact.
        div_sub = div_sh[WIDTH-1:0] - opnd_reg;
        if (div_reg) begin
            hi_next = div_ge ? div_sub : div_sh[WIDTH-1:0];
            lo_next = {lo_reg[WIDTH-2:0], div_ge};
        end else begin
            hi_next = mul_sum[WIDTH:1];
            lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};
        end
    end

    assign done = busy_reg && (cnt_reg == LAST);
    assign lo   = lo_next;
    assign hi   = hi_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= 1'b0;
            div_reg  <= 1'b0;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= '0;
            opnd_reg <= '0;
        end else if (start) begin
            busy_reg <= 1'b1;
            div_reg  <= is_div;
            cnt_reg  <= '0;
            hi_reg   <= '0;
            lo_reg   <= is_div ? a : b;
            opnd_reg <= is_div ? b : a;
        end else if (busy_reg) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (done) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// alu_seq
// Sequential ALU with valid/ready handshake on both sides. Single-cycle
// ops are evaluated combinationally from the live inputs and registered at
// the accept edge; MUL/DIV (when ALU_SEQ_MULDIV_EN is defined) run on the
// iterative alu_seq_muldiv engine for WIDTH cycles. The result is held in
// DONE until the consumer takes it.
//
// Configuration macro: ALU_SEQ_MULDIV_EN (undefined: MUL/DIV codes are
// illegal and res_hi is tied to 0).
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (a, b, sel)
//   out_valid/out_ready output handshake (res, res_hi, zf, ovf, err)
//   res                 result (low product / quotient for MUL / DIV)
//   res_hi              high product / remainder, else 0
//   zf                  res == 0
//   ovf                 signed overflow (ADD/SUB), res_hi != 0 (MUL)
//   err                 illegal sel or divide by zero
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             zf,
    output logic             ovf,
    output logic             err
);

    state_t           state_reg;
    logic [WIDTH-1:0] res_reg;
    logic             ovf_reg;
    logic             err_reg;

    logic             accept;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] op_res;
    logic [WIDTH-1:0] op_hi;
    logic             op_ovf;
    logic             op_err;

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign res       = res_reg;
    assign zf        = (res_reg == '0);
    assign ovf       = ovf_reg;
    assign err       = err_reg;

    // Single-cycle result path. MUL and non-zero DIV are handed to the
    // engine instead; their op_* values here are don't-care.
    always_comb begin
        sum    = a + b;
        diff   = a - b;
        op_res = '0;
        op_hi  = '0;
        op_ovf = 1'b0;
        op_err = 1'b0;
        case (sel)
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_ADD: begin
                op_res = sum;
                op_ovf = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1]);
            end
            OP_NOR:  op_res = ~(a | b);
            OP_SUB: begin
                op_res = diff;
                op_ovf = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff[WIDTH-1]);
            end
            OP_XOR:  op_res = a ^ b;
            OP_SLT:  op_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SGEZ: op_res = {{(WIDTH-1){1'b0}}, ~a[WIDTH-1]};
            OP_ZERO: op_res = '0;
            OP_ONES: op_res = '1;
`ifdef ALU_SEQ_MULDIV_EN
            OP_MUL:  op_res = '0;
            OP_DIV: begin
                // Only reached as a single-cycle result when b == 0.
                op_res = '1;
                op_hi  = a;
                op_err = 1'b1;
            end
`endif
            default: op_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic             md_start;
    logic             md_is_div;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] res_hi_reg;

    assign md_is_div = (sel == OP_DIV);
    assign md_start  = accept && ((sel == OP_MUL) || (md_is_div && (b != '0)));
    assign res_hi    = res_hi_reg;

    alu_seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (md_is_div),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            res_reg    <= '0;
            res_hi_reg <= '0;
            ovf_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (md_start) begin
                            state_reg <= md_is_div ? ST_DIV : ST_MUL;
                        end else begin
                            res_reg    <= op_res;
                            res_hi_reg <= op_hi;
                            ovf_reg    <= op_ovf;
                            err_reg    <= op_err;
                            state_reg  <= ST_DONE;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_done) begin
                        res_reg    <= md_lo;
                        res_hi_reg <= md_hi;
                        ovf_reg    <= (state_reg == ST_MUL) && (md_hi != '0);
                        err_reg    <= 1'b0;
                        state_reg  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`else
    // op_hi is only non-zero for divide-by-zero, which is illegal here.
    logic unused_hi;
    assign unused_hi = ^op_hi;
    assign res_hi    = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            res_reg   <= '0;
            ovf_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        res_reg   <= op_res;
                        ovf_reg   <= op_ovf;
                        err_reg   <= op_err;
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule
